sfu_ctrl: RTL
=============

// Module: sfu_ctrl
// PURPOSE
//  Sequencer for the SFU datapath: pops psum vectors from the OFIFO, drives the SFU mode and psum bus,
//  and writes finished (accumulated, ReLU'd) output vectors into PMEM at consecutive addresses.
//  Sits between OFIFO (upstream) and the SFU + PMEM write port (downstream), one tile per start.
// PARAMETERS
//  psum_bw  16  bits per psum lane
//  col      8   lanes (output channels) per vector
//  addr_bw  11  PMEM address width
//  num_out  16  output vectors written per tile
// PORTS
//  clk          in   1             clock
//  reset        in   1             asynchronous, active-high reset
//  start        in   1             begin tile; sampled only in IDLE
//  n_acc        in   4             psums accumulated per output vector (0 treated as 1); latched at start
//  relu_en      in   1             ReLU for n_acc==1 groups; latched at start
//  base_addr    in   addr_bw       first PMEM address; latched at start
//  ofifo_valid  in   1             OFIFO holds at least one vector
//  ofifo_out    in   psum_bw*col   OFIFO head vector
//  ofifo_rd     out  1             pop OFIFO this cycle
//  sfu_mode     out  2             SFU mode: 00 PASS, 01 ACC, 10 FLUSH_RELU, 11 DIRECT_RELU
//  sfu_psum     out  psum_bw*col   psum vector to SFU
//  sfu_result   in   psum_bw*col   SFU registered output
//  pmem_wen     out  1             PMEM write enable
//  pmem_addr    out  addr_bw       PMEM write address
//  pmem_din     out  psum_bw*col   PMEM write data (= sfu_result, combinational)
//  busy         out  1             high in RUN and DRAIN
//  done         out  1             one-cycle pulse at tile completion
// BEHAVIOUR
//  Reset (async): state IDLE; acc_cnt, out_cnt, pmem_wen, pmem_addr, done, busy = 0; latched cfg = 0.
//  States: IDLE -(start)-> RUN -(last pop of last group)-> DRAIN -(1 cycle)-> IDLE, done=1 next cycle.
//  start while not IDLE is ignored. Latched n_acc==0 becomes 1.
//  pop = (state==RUN) & ofifo_valid; ofifo_rd = pop (combinational). No pops in IDLE/DRAIN.
//  sfu_psum = pop ? ofifo_out : 0. When !pop: sfu_mode=ACC (adds 0; accumulators and sfu_result hold).
//  On pop, mode by acc_cnt (index within group, 0..n_acc-1):
//   - n_acc==1: DIRECT_RELU if relu_en else PASS.
//   - n_acc>1: ACC for acc_cnt<n_acc-1; FLUSH_RELU for acc_cnt==n_acc-1 (ReLU always on for n_acc>1).
//  acc_cnt increments per pop, wraps to 0 after group end. Group end = pop with acc_cnt==n_acc-1.
//  Write: cycle after a group end, pmem_wen=1 (registered), pmem_addr=base_addr+out_cnt (mod 2^addr_bw),
//   pmem_din=sfu_result (SFU output of that group, 1-cycle SFU latency). out_cnt increments with the write.
//  Writes overlap pops: back-to-back group ends (n_acc==1, ofifo_valid steady) give one write per cycle.
//  Stalls (ofifo_valid low) mid-group keep acc_cnt and SFU accumulators unchanged; no spurious writes.
//  Group end with out_cnt==num_out-1 moves RUN->DRAIN; DRAIN carries final pmem_wen; done pulses next cycle.
//  Excess OFIFO data beyond num_out*n_acc is not popped. Latency: last pop -> final write 1 cycle -> done 1 cycle.
//  Reset mid-tile: immediate return to IDLE, no further writes; SFU shares reset so accumulators clear too.
//  busy = (state!=IDLE). pmem_addr holds last value when pmem_wen=0.
// TESTING
//  1. n_acc=1, relu_en=0, base=0x10, num_out=16, valid steady, lane0 psums 5,-3,... -> 16 writes 0x10..0x1F
//     on consecutive cycles, data unchanged incl. -3; done 1 cycle after last write.
//  2. n_acc=1, relu_en=1, lane0 psum -7, lane1 +9 -> written lane0=0, lane1=9; modes all 11.
//  3. n_acc=3, lane0 psums 4,-10,3 -> modes 01,01,10; written lane0=0 (sum -3); next group 2,2,2 -> 6.
//  4. n_acc=4, ofifo_valid toggled 1,0,0,1,1,0,1 -> only 4 pops, mode 01 while idle-gap, single correct write.
//  5. base_addr=0x7FE (addr_bw=11), 4 outputs -> addresses 0x7FE,0x7FF,0x000,0x001.
//  6. reset asserted after 5 of 16 writes -> pmem_wen, busy, done drop to 0 asynchronously; start while busy ignored.

Source files
------------

// File: rtl/sfu_ctrl.sv
// -----------------------------------------------------------------------------
// sfu_ctrl
// Sequencer for the SFU datapath. It pops psum vectors from the OFIFO, drives
// the SFU mode and psum bus, and writes each finished output vector into PMEM
// at consecutive addresses. One tile (num_out output vectors) runs per start.
//
// Ports
//   clk, reset    clock; asynchronous active-high reset
//   start         begin a tile (sampled only in IDLE)
//   n_acc         psums per output vector (0 means 1), latched at start
//   relu_en       ReLU for n_acc==1 groups, latched at start
//   base_addr     first PMEM address, latched at start
//   ofifo_valid   OFIFO head holds a vector
//   ofifo_out     OFIFO head vector
//   ofifo_rd      pop strobe to the OFIFO
//   sfu_mode      00 PASS, 01 ACC, 10 FLUSH_RELU, 11 DIRECT_RELU
//   sfu_psum      psum vector to the SFU (zero when not popping)
//   sfu_result    registered SFU output
//   pmem_wen      PMEM write enable (registered)
//   pmem_addr     PMEM write address (holds when pmem_wen is low)
//   pmem_din      PMEM write data, straight from sfu_result
//   busy          high in RUN and DRAIN
//   done          one-cycle pulse at tile completion
//   dbg_state     current FSM state, for checkers
//
// Handshake: ofifo_valid/ofifo_rd is a valid/ready pair. ofifo_rd is asserted
// only in a cycle where ofifo_valid is high, and the head vector is consumed
// on the rising edge closing that cycle; ofifo_rd never depends on anything
// registered later than the current cycle.
// -----------------------------------------------------------------------------
module sfu_ctrl #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int num_out = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [3:0]               n_acc,
  input  logic                     relu_en,
  input  logic [addr_bw-1:0]       base_addr,
  input  logic                     ofifo_valid,
  input  logic [psum_bw*col-1:0]   ofifo_out,
  output logic                     ofifo_rd,
  output logic [1:0]               sfu_mode,
  output logic [psum_bw*col-1:0]   sfu_psum,
  input  logic [psum_bw*col-1:0]   sfu_result,
  output logic                     pmem_wen,
  output logic [addr_bw-1:0]       pmem_addr,
  output logic [psum_bw*col-1:0]   pmem_din,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               dbg_state
);

  localparam int OCW = $clog2(num_out + 1);

  localparam logic [1:0] M_PASS  = 2'b00;
  localparam logic [1:0] M_ACC   = 2'b01;
  localparam logic [1:0] M_FLUSH = 2'b10;
  localparam logic [1:0] M_DRELU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  logic [3:0]           r_n_acc;
  logic                 r_relu;
  logic [addr_bw-1:0]   r_base;
  logic [3:0]           r_acc_cnt;
  logic [OCW-1:0]       r_out_cnt;
  logic                 r_wen;
  logic [addr_bw-1:0]   r_addr;
  logic                 r_done;

  state_t               w_next;
  logic                 w_pop;
  logic                 w_grp_end;
  logic                 w_last_out;
  logic [3:0]           w_last_idx;
  logic [1:0]           w_mode;

  always_comb begin
    w_next     = r_state;
    w_pop      = (r_state == S_RUN) && ofifo_valid;
    w_last_idx = r_n_acc - 4'd1;
    w_grp_end  = w_pop && (r_acc_cnt == w_last_idx);
    w_last_out = (r_out_cnt == OCW'(num_out - 1));
    // Idle cycles keep the SFU in ACC with a zero psum so its state holds.
    w_mode     = M_ACC;
    if (w_pop) begin
      if (r_n_acc == 4'd1) begin
        w_mode = r_relu ? M_DRELU : M_PASS;
      end else if (r_acc_cnt == w_last_idx) begin
        w_mode = M_FLUSH;
      end else begin
        w_mode = M_ACC;
      end
    end
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_grp_end && w_last_out) w_next = S_DRAIN;
      S_DRAIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_n_acc   <= 4'd0;
      r_relu    <= 1'b0;
      r_base    <= '0;
      r_acc_cnt <= 4'd0;
      r_out_cnt <= '0;
      r_wen     <= 1'b0;
      r_addr    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_next;
      // The SFU result of a group is valid one cycle after its last pop,
      // so the write strobe is the group-end strobe delayed by one cycle.
      r_wen   <= w_grp_end;
      r_done  <= (r_state == S_DRAIN);
      if ((r_state == S_IDLE) && start) begin
        r_n_acc   <= (n_acc == 4'd0) ? 4'd1 : n_acc;
        r_relu    <= relu_en;
        r_base    <= base_addr;
        r_acc_cnt <= 4'd0;
        r_out_cnt <= '0;
      end else if (w_grp_end) begin
        r_acc_cnt <= 4'd0;
        // Address wraps naturally at addr_bw bits.
        r_addr    <= r_base + addr_bw'(r_out_cnt);
        r_out_cnt <= r_out_cnt + OCW'(1);
      end else if (w_pop) begin
        r_acc_cnt <= r_acc_cnt + 4'd1;
      end
    end
  end

  assign ofifo_rd  = w_pop;
  assign sfu_mode  = w_mode;
  assign sfu_psum  = w_pop ? ofifo_out : '0;
  assign pmem_wen  = r_wen;
  assign pmem_addr = r_addr;
  assign pmem_din  = sfu_result;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule
